frame_buffer_arbiter: RTL and testbench

Arbitrates the single-port 192-entry pixel buffer (3 channels x 8 rows x 8 columns, address = {cha[1:0], row[2:0], col[2:0]}) between two requesters. The producer is the frame loader, which writes. The consumer is the read-sequencing controller, which reads. A frame-valid lock enforces strict producer/consumer alternation: a frame must be fully written before it is read, and fully read before it is overwritten. The block also tracks the buffer's read latency, so the consumer receives an aligned data-valid strobe.

---
 rtl/frame_buffer_arbiter.sv | 149 ++++++++++++++
 tb/tb_frame_buffer_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_arbiter.sv
// Single-port pixel buffer arbiter: frame-valid lock between one writer and one reader,
// with a read-latency pipeline that delivers an aligned rd_valid strobe.
module frame_buffer_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 192,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    output logic              wr_gnt,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_done,
    input  logic              rd_req,
    output logic              rd_gnt,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    input  logic              rd_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              frame_valid,
    output logic              busy,
    output logic              addr_err
);

    typedef enum logic [1:0] {IDLE, WR_OWN, RD_OWN, RD_DRAIN} state_t;

    localparam int                CNT_W      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(RD_LAT - 1);
    localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic                wr_gnt_q, wr_gnt_d;
    logic                rd_gnt_q, rd_gnt_d;
    logic                frame_valid_q, frame_valid_d;
    logic                addr_err_q, addr_err_d;
    logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic [RD_LAT-1:0]   rd_pipe_q, rd_pipe_d;

    logic wr_legal, rd_legal, wr_strobe, rd_strobe;

    assign wr_legal  = ({1'b0, wr_addr} < DEPTH_C);
    assign rd_legal  = ({1'b0, rd_addr} < DEPTH_C);
    assign wr_strobe = wr_en & wr_gnt_q;
    assign rd_strobe = rd_en & rd_gnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            wr_gnt_q      <= 1'b0;
            rd_gnt_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            drain_cnt_q   <= '0;
            rd_pipe_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_gnt_q      <= wr_gnt_d;
            rd_gnt_q      <= rd_gnt_d;
            frame_valid_q <= frame_valid_d;
            addr_err_q    <= addr_err_d;
            drain_cnt_q   <= drain_cnt_d;
            rd_pipe_q     <= rd_pipe_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        frame_valid_d = frame_valid_q;
        drain_cnt_d   = drain_cnt_q;
        case (state_q)
            IDLE: begin
                // frame_valid makes at most one requester eligible, so no tie-break is needed
                if (wr_req && !frame_valid_q) begin
                    state_d = WR_OWN;
                end else if (rd_req && frame_valid_q) begin
                    state_d = RD_OWN;
                end
            end
            WR_OWN: begin
                if (wr_done) begin
                    state_d       = IDLE;
                    frame_valid_d = 1'b1;
                end
            end
            RD_OWN: begin
                if (rd_done) begin
                    state_d     = RD_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            RD_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d       = IDLE;
                    frame_valid_d = 1'b0;
                    drain_cnt_d   = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Grants are registered copies of the next state, so they track *_OWN exactly.
        wr_gnt_d   = (state_d == WR_OWN);
        rd_gnt_d   = (state_d == RD_OWN);
        addr_err_d = addr_err_q | (wr_strobe & ~wr_legal) | (rd_strobe & ~rd_legal);

        rd_pipe_d    = '0;
        rd_pipe_d[0] = rd_strobe & rd_legal;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
    end

    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        case (state_q)
            WR_OWN: begin
                mem_en   = wr_en & wr_legal;
                mem_we   = wr_en & wr_legal;
                mem_addr = wr_addr;
                mem_din  = wr_data;
            end
            RD_OWN: begin
                mem_en   = rd_en & rd_legal;
                mem_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign wr_gnt      = wr_gnt_q;
    assign rd_gnt      = rd_gnt_q;
    assign rd_valid    = rd_pipe_q[RD_LAT-1];
    assign frame_valid = frame_valid_q;
    assign busy        = (state_q != IDLE);
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Self-checking bench for frame_buffer_arbiter: per-scenario tasks plus a scoreboard
// of expected rd_valid cycles fed as reads are issued.
module tb_frame_buffer_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_req, wr_en, wr_done, rd_req, rd_en, rd_done;
    logic [7:0] wr_addr, wr_data, rd_addr;
    logic       wr_gnt, rd_gnt, rd_valid, mem_en, mem_we, frame_valid, busy, addr_err;
    logic [7:0] mem_addr, mem_din;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int sb[$];

    frame_buffer_arbiter #(.ADDR_W(8), .DATA_W(8), .DEPTH(192), .RD_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_done(wr_done),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_done(rd_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .frame_valid(frame_valid), .busy(busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // rd_valid must appear exactly in the cycle recorded when each accepted read was issued
    always @(negedge clk) begin
        if (reset) begin
            if (sb.size() > 0 && sb[0] == cyc) begin
                int e;
                e = sb.pop_front();
                checks++;
                if (rd_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rd_valid_missing cyc=%0d got=%b required=1 (expected cyc %0d)", cyc, rd_valid, e);
                end
            end else if (rd_valid === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_unexpected cyc=%0d got=1 required=0", cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        wr_req = 0; wr_en = 0; wr_done = 0; wr_addr = '0; wr_data = '0;
        rd_req = 0; rd_en = 0; rd_done = 0; rd_addr = '0;
    endtask

    task automatic apply_reset;
        reset = 0;
        clear_inputs();
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
    endtask

    task automatic write_frame;
        int n = 0;
        wr_req = 1;
        @(negedge clk);
        while (wr_gnt !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wr_gnt !== 1'b1) begin
            errors++;
            $display("FAIL write_frame_grant got=%b required=1", wr_gnt);
        end
        for (int i = 0; i < 192; i++) begin
            step();
            wr_en = 1; wr_addr = 8'(i); wr_data = 8'(i);
            wr_done = (i == 191); wr_req = (i != 191);
        end
        step();
        wr_en = 0; wr_done = 0;
    endtask

    task automatic read_frame;
        int n = 0;
        rd_req = 1;
        @(negedge clk);
        while (rd_gnt !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rd_gnt !== 1'b1) begin
            errors++;
            $display("FAIL read_frame_grant got=%b required=1", rd_gnt);
        end
        for (int i = 0; i < 192; i++) begin
            step();
            rd_en = 1; rd_addr = 8'(i);
            rd_done = (i == 191); rd_req = (i != 191);
            sb.push_back(cyc + 2);
        end
        step();
        rd_en = 0; rd_done = 0;
    endtask

    task automatic test_reset;
        reset = 0;
        clear_inputs();
        #3;
        checks++;
        if ({wr_gnt, rd_gnt, rd_valid, mem_en, mem_we, frame_valid, busy, addr_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=00000000",
                     {wr_gnt, rd_gnt, rd_valid, mem_en, mem_we, frame_valid, busy, addr_err});
        end
        checks++;
        if ({mem_addr, mem_din} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mem got=%h required=0000", {mem_addr, mem_din});
        end
        apply_reset();
        wr_en = 1; wr_addr = 8'd250; rd_en = 1; rd_addr = 8'd250; wr_done = 1; rd_done = 1;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) begin
            errors++;
            $display("FAIL nonowner_mem_en got=%b required=0", mem_en);
        end
        step();
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({addr_err, busy, frame_valid} !== 3'b000) begin
            errors++;
            $display("FAIL nonowner_ignored got=%b required=000", {addr_err, busy, frame_valid});
        end
    endtask

    task automatic test_write_read;
        apply_reset();
        wr_req = 1;
        @(negedge clk);
        checks++;
        if ({wr_gnt, busy} !== 2'b00) begin
            errors++;
            $display("FAIL wr_gnt_early got=%b required=00", {wr_gnt, busy});
        end
        for (int i = 0; i < 192; i++) begin
            step();
            wr_en = 1; wr_addr = 8'(i); wr_data = 8'(i);
            wr_done = (i == 191); wr_req = (i != 191);
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if ({wr_gnt, busy} !== 2'b11) begin
                    errors++;
                    $display("FAIL wr_gnt_timing got=%b required=11", {wr_gnt, busy});
                end
            end
            checks++;
            if ({mem_en, mem_we, mem_addr, mem_din} !== {2'b11, 8'(i), 8'(i)}) begin
                errors++;
                $display("FAIL write_mem_path i=%0d got=%h required=%h", i,
                         {mem_en, mem_we, mem_addr, mem_din}, {2'b11, 8'(i), 8'(i)});
            end
        end
        step();
        wr_en = 0; wr_done = 0;
        rd_req = 1;
        @(negedge clk);
        checks++;
        if ({frame_valid, wr_gnt, busy, mem_en} !== 4'b1000) begin
            errors++;
            $display("FAIL after_wr_done got=%b required=1000", {frame_valid, wr_gnt, busy, mem_en});
        end
        for (int i = 0; i < 192; i++) begin
            step();
            rd_en = 1; rd_addr = 8'(i);
            rd_done = (i == 191); rd_req = (i != 191);
            sb.push_back(cyc + 2);
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (rd_gnt !== 1'b1) begin
                    errors++;
                    $display("FAIL rd_gnt_timing got=%b required=1", rd_gnt);
                end
            end
            checks++;
            if ({mem_en, mem_we, mem_addr, mem_din} !== {2'b10, 8'(i), 8'h00}) begin
                errors++;
                $display("FAIL read_mem_path i=%0d got=%h required=%h", i,
                         {mem_en, mem_we, mem_addr, mem_din}, {2'b10, 8'(i), 8'h00});
            end
        end
        step();
        rd_en = 0; rd_done = 0;
        @(negedge clk);
        checks++;
        if ({rd_gnt, busy, mem_en, frame_valid} !== 4'b0101) begin
            errors++;
            $display("FAIL drain_first got=%b required=0101", {rd_gnt, busy, mem_en, frame_valid});
        end
        step();
        @(negedge clk);
        checks++;
        if ({rd_gnt, busy} !== 2'b01) begin
            errors++;
            $display("FAIL drain_second got=%b required=01", {rd_gnt, busy});
        end
        step();
        @(negedge clk);
        checks++;
        if ({busy, frame_valid} !== 2'b00 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain_exit got=%b pending=%0d required=00 pending=0", {busy, frame_valid}, sb.size());
        end
    endtask

    task automatic test_lock;
        apply_reset();
        write_frame();
        wr_req = 1;
        for (int i = 0; i < 50; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (wr_gnt !== 1'b0) begin
                errors++;
                $display("FAIL lock_hold i=%0d got=%b required=0", i, wr_gnt);
            end
        end
        read_frame();
        repeat (2) step();
        @(negedge clk);
        checks++;
        if ({wr_gnt, busy} !== 2'b00) begin
            errors++;
            $display("FAIL lock_idle got=%b required=00", {wr_gnt, busy});
        end
        step();
        @(negedge clk);
        checks++;
        if (wr_gnt !== 1'b1) begin
            errors++;
            $display("FAIL lock_release got=%b required=1", wr_gnt);
        end
    endtask

    task automatic test_simultaneous;
        apply_reset();
        wr_req = 1; rd_req = 1;
        step();
        @(negedge clk);
        checks++;
        if ({wr_gnt, rd_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL simul_grant got=%b required=10", {wr_gnt, rd_gnt});
        end
        step();
        wr_en = 1; wr_addr = 8'd7; wr_data = 8'h5a; wr_done = 1; wr_req = 0;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_din} !== {2'b11, 8'd7, 8'h5a}) begin
            errors++;
            $display("FAIL simul_write got=%h required=%h", {mem_en, mem_we, mem_addr, mem_din}, {2'b11, 8'd7, 8'h5a});
        end
        step();
        wr_en = 0; wr_done = 0;
        @(negedge clk);
        checks++;
        if ({rd_gnt, frame_valid} !== 2'b01) begin
            errors++;
            $display("FAIL simul_idle got=%b required=01", {rd_gnt, frame_valid});
        end
        step();
        @(negedge clk);
        checks++;
        if ({rd_gnt, wr_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL simul_reader_next got=%b required=10", {rd_gnt, wr_gnt});
        end
        step();
        rd_done = 1; rd_req = 0;
        step();
        rd_done = 0;
        repeat (2) step();
        @(negedge clk);
        checks++;
        if ({busy, frame_valid} !== 2'b00) begin
            errors++;
            $display("FAIL simul_done got=%b required=00", {busy, frame_valid});
        end
    endtask

    task automatic test_illegal;
        int n = 0;
        apply_reset();
        wr_req = 1;
        @(negedge clk);
        while (wr_gnt !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        step();
        wr_en = 1; wr_addr = 8'd192; wr_data = 8'h01;
        @(negedge clk);
        checks++;
        if ({wr_gnt, mem_en, mem_we, addr_err} !== 4'b1000) begin
            errors++;
            $display("FAIL illegal_wr_suppress got=%b required=1000", {wr_gnt, mem_en, mem_we, addr_err});
        end
        step();
        wr_addr = 8'd191; wr_data = 8'h03;
        @(negedge clk);
        checks++;
        if ({addr_err, mem_en} !== 2'b11) begin
            errors++;
            $display("FAIL illegal_wr_flag got=%b required=11", {addr_err, mem_en});
        end
        step();
        wr_en = 0; wr_done = 1; wr_req = 0;
        step();
        wr_done = 0; rd_req = 1;
        n = 0;
        @(negedge clk);
        while (rd_gnt !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        step();
        rd_en = 1; rd_addr = 8'd200;
        @(negedge clk);
        checks++;
        if ({rd_gnt, mem_en} !== 2'b10) begin
            errors++;
            $display("FAIL illegal_rd_suppress got=%b required=10", {rd_gnt, mem_en});
        end
        step();
        rd_addr = 8'd191; rd_done = 1; rd_req = 0;
        sb.push_back(cyc + 2);
        step();
        rd_en = 0; rd_done = 0;
        repeat (2) step();
        @(negedge clk);
        checks++;
        if ({busy, addr_err} !== 2'b01 || sb.size() != 0) begin
            errors++;
            $display("FAIL illegal_rd_drain got=%b pending=%0d required=01 pending=0", {busy, addr_err}, sb.size());
        end
        write_frame();
        @(negedge clk);
        checks++;
        if ({addr_err, frame_valid} !== 2'b11) begin
            errors++;
            $display("FAIL addr_err_sticky got=%b required=11", {addr_err, frame_valid});
        end
    endtask

    task automatic test_reset_mid_read;
        int n = 0;
        apply_reset();
        write_frame();
        rd_req = 1;
        @(negedge clk);
        while (rd_gnt !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 40; i++) begin
            step();
            rd_en = 1; rd_addr = 8'(i);
            sb.push_back(cyc + 2);
        end
        #2;
        reset = 0;
        sb.delete();
        #1;
        checks++;
        if ({rd_gnt, rd_valid, frame_valid, busy, mem_en} !== 5'b00000) begin
            errors++;
            $display("FAIL mid_read_reset got=%b required=00000", {rd_gnt, rd_valid, frame_valid, busy, mem_en});
        end
        rd_en = 0;
        step();
        reset = 1;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if ({rd_gnt, busy} !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_rd_held got=%b required=00", {rd_gnt, busy});
        end
        wr_req = 1;
        step();
        @(negedge clk);
        checks++;
        if ({wr_gnt, rd_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_wr_grant got=%b required=10", {wr_gnt, rd_gnt});
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        test_reset();
        test_write_read();
        test_lock();
        test_simultaneous();
        test_illegal();
        test_reset_mid_read();
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
